// File: rtl/hub75_fb_loader_if.sv
// Bundles the pixel stream, framebuffer-write bus, frame handshake and status
// outputs of hub75_fb_loader.
// master: the loader itself; slave: the video source plus framebuffer side.
interface hub75_fb_loader_if #(
    parameter int unsigned N_BANKS  = 2,
    parameter int unsigned N_ROWS   = 32,
    parameter int unsigned N_COLS   = 64,
    parameter int unsigned BITDEPTH = 24
);
    localparam int unsigned LOG_N_BANKS = $clog2(N_BANKS);
    localparam int unsigned LOG_N_ROWS  = $clog2(N_ROWS);
    localparam int unsigned LOG_N_COLS  = $clog2(N_COLS);

    // Pixel stream
    logic [BITDEPTH-1:0]    in_data;
    logic                   in_sof;
    logic                   in_valid;
    logic                   in_ready;
    // Framebuffer write bus
    logic [LOG_N_BANKS-1:0] fbw_bank_addr;
    logic [LOG_N_ROWS-1:0]  fbw_row_addr;
    logic                   fbw_row_store;
    logic                   fbw_row_rdy;
    logic                   fbw_row_swap;
    logic [BITDEPTH-1:0]    fbw_data;
    logic [LOG_N_COLS-1:0]  fbw_col_addr;
    logic                   fbw_wren;
    // Frame handshake and status
    logic                   frame_swap;
    logic                   frame_rdy;
    logic                   fb_loaded;
    logic [15:0]            stat_frames;
    logic [7:0]             stat_resync;

    modport master (
        input  in_data, in_sof, in_valid, fbw_row_rdy, frame_rdy,
        output in_ready, fbw_bank_addr, fbw_row_addr, fbw_row_store, fbw_row_swap,
               fbw_data, fbw_col_addr, fbw_wren, frame_swap, fb_loaded,
               stat_frames, stat_resync
    );

    modport slave (
        output in_data, in_sof, in_valid, fbw_row_rdy, frame_rdy,
        input  in_ready, fbw_bank_addr, fbw_row_addr, fbw_row_store, fbw_row_swap,
               fbw_data, fbw_col_addr, fbw_wren, frame_swap, fb_loaded,
               stat_frames, stat_resync
    );
endinterface

// File: rtl/hub75_fb_loader.sv
// Packs a raster pixel stream into line-buffer writes, row store/swap commands
// and frame swap commands for the HUB75 framebuffer. All outputs registered.
// Optional macro HUB75_FB_LOADER_STATS_EN enables the frame/resync counters;
// without it stat_frames/stat_resync are tied to 0.
module hub75_fb_loader #(
    parameter int unsigned N_BANKS  = 2,
    parameter int unsigned N_ROWS   = 32,
    parameter int unsigned N_COLS   = 64,
    parameter int unsigned BITDEPTH = 24
) (
    input  logic              clk,
    input  logic              rst,
    hub75_fb_loader_if.master bus
);
    localparam int unsigned LOG_N_BANKS = $clog2(N_BANKS);
    localparam int unsigned LOG_N_ROWS  = $clog2(N_ROWS);
    localparam int unsigned LOG_N_COLS  = $clog2(N_COLS);
    localparam int unsigned LINE_W      = LOG_N_BANKS + LOG_N_ROWS;

    localparam logic [LINE_W-1:0]     LastLine = LINE_W'(N_BANKS * N_ROWS - 1);
    localparam logic [LOG_N_COLS-1:0] LastCol  = LOG_N_COLS'(N_COLS - 1);

    typedef enum logic [2:0] {StIdle, StFill, StStore, StFswap, StSwait} state_e;

    state_e                 state_q, state_d;
    logic                   first_q, first_d;   // first cycle in the current state
    logic [LOG_N_COLS-1:0]  col_q, col_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic                   in_ready_q, in_ready_d;
    logic                   wren_q, wren_d;
    logic [BITDEPTH-1:0]    data_q, data_d;
    logic [LOG_N_COLS-1:0]  col_addr_q, col_addr_d;
    logic [LOG_N_BANKS-1:0] bank_q, bank_d;
    logic [LOG_N_ROWS-1:0]  row_q, row_d;
    logic                   row_store_q, row_store_d;
    logic                   frame_swap_q, frame_swap_d;
    logic                   fb_loaded_q, fb_loaded_d;
    logic                   accept;

    assign accept = bus.in_valid & in_ready_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        line_d       = line_q;
        wren_d       = 1'b0;
        data_d       = data_q;
        col_addr_d   = col_addr_q;
        bank_d       = bank_q;
        row_d        = row_q;
        row_store_d  = 1'b0;
        frame_swap_d = 1'b0;
        fb_loaded_d  = fb_loaded_q;

        unique case (state_q)
            StIdle: begin
                if (accept && bus.in_sof) begin
                    wren_d     = 1'b1;
                    data_d     = bus.in_data;
                    col_addr_d = '0;
                    col_d      = LOG_N_COLS'(1);
                    line_d     = '0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (accept) begin
                    wren_d = 1'b1;
                    data_d = bus.in_data;
                    if (bus.in_sof) begin
                        // Resync: abandon the partial frame, restart at line 0.
                        col_addr_d = '0;
                        col_d      = LOG_N_COLS'(1);
                        line_d     = '0;
                    end else begin
                        col_addr_d = col_q;
                        col_d      = col_q + 1'b1;
                        if (col_q == LastCol) begin
                            state_d = StStore;
                        end
                    end
                end
            end
            StStore: begin
                // Skip the entry cycle so the row's final write is already out.
                if (!first_q && bus.fbw_row_rdy) begin
                    row_store_d = 1'b1;
                    bank_d      = line_q[LINE_W-1:LOG_N_ROWS];
                    row_d       = line_q[LOG_N_ROWS-1:0];
                    if (line_q == LastLine) begin
                        state_d = StFswap;
                    end else begin
                        line_d  = line_q + 1'b1;
                        state_d = StFill;
                    end
                end
            end
            StFswap: begin
                if (bus.fbw_row_rdy && bus.frame_rdy) begin
                    frame_swap_d = 1'b1;
                    fb_loaded_d  = 1'b1;
                    state_d      = StSwait;
                end
            end
            StSwait: begin
                // frame_rdy lags the swap pulse by a cycle upstream.
                if (!first_q && bus.frame_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StIdle) || (state_d == StFill);
        first_d    = (state_d != state_q);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            first_q      <= 1'b0;
            col_q        <= '0;
            line_q       <= '0;
            in_ready_q   <= 1'b0;
            wren_q       <= 1'b0;
            data_q       <= '0;
            col_addr_q   <= '0;
            bank_q       <= '0;
            row_q        <= '0;
            row_store_q  <= 1'b0;
            frame_swap_q <= 1'b0;
            fb_loaded_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            col_q        <= col_d;
            line_q       <= line_d;
            in_ready_q   <= in_ready_d;
            wren_q       <= wren_d;
            data_q       <= data_d;
            col_addr_q   <= col_addr_d;
            bank_q       <= bank_d;
            row_q        <= row_d;
            row_store_q  <= row_store_d;
            frame_swap_q <= frame_swap_d;
            fb_loaded_q  <= fb_loaded_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.fbw_wren      = wren_q;
    assign bus.fbw_data      = data_q;
    assign bus.fbw_col_addr  = col_addr_q;
    assign bus.fbw_bank_addr = bank_q;
    assign bus.fbw_row_addr  = row_q;
    assign bus.fbw_row_store = row_store_q;
    assign bus.fbw_row_swap  = row_store_q;
    assign bus.frame_swap    = frame_swap_q;
    assign bus.fb_loaded     = fb_loaded_q;

`ifdef HUB75_FB_LOADER_STATS_EN
    logic [15:0] stat_frames_q, stat_frames_d;
    logic [7:0]  stat_resync_q, stat_resync_d;

    // Frame count wraps; resync count saturates at 255.
    always_comb begin
        stat_frames_d = stat_frames_q + {15'd0, frame_swap_d};
        stat_resync_d = stat_resync_q;
        if ((state_q == StFill) && accept && bus.in_sof && (stat_resync_q != 8'hff)) begin
            stat_resync_d = stat_resync_q + 8'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frames_q <= '0;
            stat_resync_q <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_resync_q <= stat_resync_d;
        end
    end

    assign bus.stat_frames = stat_frames_q;
    assign bus.stat_resync = stat_resync_q;
`else
    assign bus.stat_frames = '0;
    assign bus.stat_resync = '0;
`endif
endmodule

// File: tb/tb_hub75_fb_loader.sv
// Self-checking bench for hub75_fb_loader: directed scenarios plus randomized
// frames, checked every cycle against a pixel-level frame model.
module tb_hub75_fb_loader;
    localparam int NB = 2;
    localparam int NR = 4;
    localparam int NC = 8;
    localparam int BD = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hub75_fb_loader_if #(.N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .BITDEPTH(BD)) bus ();

    hub75_fb_loader #(.N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .BITDEPTH(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_rdy = 0;

    // Model state: pending events derived from accepted pixels
    int exp_wr_col[$];
    int exp_wr_data[$];
    int exp_st[$];
    int frames_pending = 0;
    bit exp_wr_now = 0;
    bit m_fill = 0;
    int m_line = 0;
    int m_col = 0;
    int m_resync = 0;
    int m_swaps = 0;
    bit prev_store = 0, prev_fswap = 0, prev_row_rdy = 0, prev_frame_rdy = 0;

    // Observation logs (never cleared)
    int wr_col_log[$];
    int wr_data_log[$];
    int st_bank_log[$];
    int st_row_log[$];
    int frames_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_wr_col.delete(); exp_wr_data.delete(); exp_st.delete();
                frames_pending = 0; exp_wr_now = 0; m_fill = 0; m_line = 0; m_col = 0;
                m_resync = 0; m_swaps = 0;
                prev_store = 0; prev_fswap = 0; prev_row_rdy = 0; prev_frame_rdy = 0;
            end else begin
                chk("wren_timing", bus.fbw_wren, exp_wr_now);
                if (bus.fbw_wren) begin
                    wr_col_log.push_back(int'(bus.fbw_col_addr));
                    wr_data_log.push_back(int'(bus.fbw_data));
                end
                if (bus.fbw_wren && exp_wr_now && exp_wr_col.size() > 0) begin
                    chk("wr_col", bus.fbw_col_addr, exp_wr_col.pop_front());
                    chk("wr_data", bus.fbw_data, exp_wr_data.pop_front());
                end
                chk("swap_eq_store", bus.fbw_row_swap, bus.fbw_row_store);
                if (bus.fbw_row_store) begin
                    st_bank_log.push_back(int'(bus.fbw_bank_addr));
                    st_row_log.push_back(int'(bus.fbw_row_addr));
                    chk("store_no_wren", bus.fbw_wren, 0);
                    chk("store_single", prev_store, 0);
                    chk("store_rdy", prev_row_rdy, 1);
                    chk("store_after_writes", exp_wr_col.size(), 0);
                    chk("store_expected", exp_st.size() > 0, 1);
                    if (exp_st.size() > 0)
                        chk("store_line", int'(bus.fbw_bank_addr) * NR + int'(bus.fbw_row_addr),
                            exp_st.pop_front());
                end
                if (bus.frame_swap) begin
                    frames_seen++;
                    m_swaps++;
                    chk("fswap_no_wren", bus.fbw_wren, 0);
                    chk("fswap_no_store", bus.fbw_row_store, 0);
                    chk("fswap_single", prev_fswap, 0);
                    chk("fswap_rdy", {prev_row_rdy, prev_frame_rdy}, 2'b11);
                    chk("fswap_after_stores", exp_st.size(), 0);
                    chk("fswap_expected", frames_pending > 0, 1);
                    if (frames_pending > 0) frames_pending--;
                end
                chk("fb_loaded", bus.fb_loaded, m_swaps > 0);
                if (exp_st.size() > 0 || frames_pending > 0)
                    chk("in_ready_blocked", bus.in_ready, 0);
`ifdef HUB75_FB_LOADER_STATS_EN
                chk("stat_frames", bus.stat_frames, 16'(m_swaps));
                chk("stat_resync", bus.stat_resync, (m_resync > 255) ? 255 : m_resync);
`else
                chk("stat_frames", bus.stat_frames, 0);
                chk("stat_resync", bus.stat_resync, 0);
`endif
                // Advance the model with this cycle's accepted pixel
                exp_wr_now = 0;
                if (bus.in_valid && bus.in_ready) begin
                    if (bus.in_sof) begin
                        if (m_fill) m_resync++;
                        m_fill = 1; m_line = 0; m_col = 0;
                    end
                    if (m_fill) begin
                        exp_wr_col.push_back(m_col);
                        exp_wr_data.push_back(int'(bus.in_data));
                        exp_wr_now = 1;
                        m_col++;
                        if (m_col == NC) begin
                            m_col = 0;
                            exp_st.push_back(m_line);
                            if (m_line == NB * NR - 1) begin
                                frames_pending++;
                                m_fill = 0;
                            end else begin
                                m_line++;
                            end
                        end
                    end
                end
                prev_store     = bus.fbw_row_store;
                prev_fswap     = bus.frame_swap;
                prev_row_rdy   = bus.fbw_row_rdy;
                prev_frame_rdy = bus.frame_rdy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            bus.fbw_row_rdy = ($urandom_range(0, 3) != 0);
            bus.frame_rdy   = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send(input logic [BD-1:0] d, input logic s);
        logic acc;
        int guard;
        bus.in_data  = d;
        bus.in_sof   = s;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 300) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        chk("pixel_accepted", acc, 1);
    endtask

    task automatic send_run(input int n, input int base, input bit first_sof, input bit rnd);
        for (int i = 0; i < n; i++) begin
            logic s;
            logic [BD-1:0] d;
            s = (i == 0) && first_sof;
            if (rnd && $urandom_range(0, 63) == 0) s = 1'b1;
            d = rnd ? BD'($urandom) : BD'(base + i);
            send(d, s);
            if (rnd && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (g < 2000 && !(exp_wr_col.size() == 0 && exp_st.size() == 0 &&
                             frames_pending == 0 && bus.in_ready)) begin
            tick();
            g++;
        end
        chk(name, g < 2000, 1);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_in_ready"}, bus.in_ready, 0);
        chk({name, "_strobes"}, {bus.fbw_wren, bus.fbw_row_store, bus.fbw_row_swap,
                                 bus.frame_swap, bus.fb_loaded}, 0);
        chk({name, "_addrs"}, {bus.fbw_bank_addr, bus.fbw_row_addr, bus.fbw_col_addr}, 0);
        chk({name, "_data"}, bus.fbw_data, 0);
        chk({name, "_stats"}, {bus.stat_frames, bus.stat_resync}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, s0, f0, g;
        rst = 1'b1;
        bus.in_data = '0; bus.in_sof = 1'b0; bus.in_valid = 1'b0;
        bus.fbw_row_rdy = 1'b1; bus.frame_rdy = 1'b1;
        #1;
        check_reset_vals("reset_init");
        tick(); tick();
        rst = 1'b0;
        tick();

        // Pixels without sof are swallowed
        w0 = wr_col_log.size(); s0 = st_bank_log.size(); f0 = frames_seen;
        for (int i = 0; i < 5; i++) send(BD'(500 + i), 1'b0);
        repeat (3) tick();
        chk("nosof_no_wren", wr_col_log.size() - w0, 0);
        chk("nosof_no_store", st_bank_log.size() - s0, 0);
        chk("nosof_no_fswap", frames_seen - f0, 0);

        // Full frame 0..63
        w0 = wr_col_log.size(); s0 = st_bank_log.size(); f0 = frames_seen;
        send_run(64, 0, 1, 0);
        drain("frame1_drain");
        chk("frame1_writes", wr_col_log.size() - w0, 64);
        chk("frame1_stores", st_bank_log.size() - s0, 8);
        chk("frame1_fswaps", frames_seen - f0, 1);
        chk("frame1_loaded", bus.fb_loaded, 1);
        chk("frame1_wr9", {wr_col_log[w0 + 9], wr_data_log[w0 + 9]}, {32'd1, 32'd9});
        chk("frame1_wr63", {wr_col_log[w0 + 63], wr_data_log[w0 + 63]}, {32'd7, 32'd63});
        chk("frame1_st0", {st_bank_log[s0], st_row_log[s0]}, {32'd0, 32'd0});
        chk("frame1_st3", {st_bank_log[s0 + 3], st_row_log[s0 + 3]}, {32'd0, 32'd3});
        chk("frame1_st4", {st_bank_log[s0 + 4], st_row_log[s0 + 4]}, {32'd1, 32'd0});
        chk("frame1_st7", {st_bank_log[s0 + 7], st_row_log[s0 + 7]}, {32'd1, 32'd3});

        // Store held off by fbw_row_rdy
        bus.fbw_row_rdy = 1'b0;
        send_run(8, 1000, 1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rowrdy_hold_store", bus.fbw_row_store, 0);
            chk("rowrdy_hold_ready", bus.in_ready, 0);
            tick();
        end
        bus.fbw_row_rdy = 1'b1;
        @(negedge clk);
        chk("rowrdy_not_yet", bus.fbw_row_store, 0);
        tick();
        @(negedge clk);
        chk("rowrdy_store_pulse", {bus.fbw_row_store, bus.fbw_row_swap}, 2'b11);
        tick();
        send_run(56, 1008, 0, 0);
        drain("rowrdy_drain");

        // Resync at pixel 20
        s0 = st_bank_log.size(); f0 = frames_seen;
        send_run(20, 2000, 1, 0);
        send_run(64, 3000, 1, 0);
        drain("resync_drain");
        chk("resync_stores", st_bank_log.size() - s0, 10);
        chk("resync_restart_line0", {st_bank_log[s0 + 2], st_row_log[s0 + 2]}, 0);
        chk("resync_fswaps", frames_seen - f0, 1);
`ifdef HUB75_FB_LOADER_STATS_EN
        chk("resync_count", bus.stat_resync, 1);
`else
        chk("resync_count", bus.stat_resync, 0);
`endif

        // Frame swap held off by frame_rdy
        bus.frame_rdy = 1'b0;
        send_run(64, 4000, 1, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("framerdy_hold", bus.frame_swap, 0);
            tick();
        end
        bus.frame_rdy = 1'b1;
        tick();
        bus.frame_rdy = 1'b0;
        @(negedge clk);
        chk("framerdy_pulse", bus.frame_swap, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("swait_ready_low", bus.in_ready, 0);
        end
        bus.frame_rdy = 1'b1;
        g = 0;
        while (g < 10 && !bus.in_ready) begin
            tick();
            g++;
        end
        chk("swait_release", bus.in_ready, 1);

        // Asynchronous reset mid-line 3
        send_run(27, 5000, 1, 0);
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("reset_mid");
        tick(); tick();
        rst = 1'b0;
        tick();
        s0 = st_bank_log.size();
        send_run(64, 6000, 1, 0);
        drain("post_reset_drain");
        chk("post_reset_stores", st_bank_log.size() - s0, 8);
        chk("post_reset_st0", {st_bank_log[s0], st_row_log[s0]}, 0);

        // Randomized frames, gaps and backpressure
        rand_rdy = 1;
        for (int f = 0; f < 5; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) send(BD'($urandom), 1'b0);
            send_run(64, 0, 1, 1);
        end
        send_run(64, 0, 1, 0);
        drain("random_drain");
        rand_rdy = 0;
        bus.fbw_row_rdy = 1'b1;
        bus.frame_rdy = 1'b1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
